// File: rtl/hazard_pkg.sv
// Shared types and forward-select encoding for the ID-stage hazard/forwarding controller.
package hazard_pkg;

   // Scoreboard rd field is sized for the widest register file we expect to build.
   localparam int RD_W_MAX = 8;

   localparam int FWD_RF     = 0;
   localparam int FWD_EX_MEM = 1;
   localparam int FWD_MEM_WB = 2;

   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      logic                regwrite;
      logic                memread;
   } sb_entry_t;

   typedef enum logic {
      IDLE,
      FLUSHING
   } flush_state_t;

   function automatic logic writes_reg(sb_entry_t e);
      return e.valid & e.regwrite & (e.rd != '0);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand scoreboard search: youngest in-flight producer of rs, and whether a
// load that rs depends on is still too close to forward from.
module fwd_match
   import hazard_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = 2
) (
   input  sb_entry_t [DEPTH-1:0] sb,
   input  logic [REG_AW-1:0]     rs,
   input  logic                  used,
   output logic [SEL_W-1:0]      sel,
   output logic                  load_hit
);

   logic [RD_W_MAX-1:0] rs_ext;
   logic [DEPTH-1:0]    hit;
   logic                found;

   assign rs_ext = RD_W_MAX'(rs);

   always_comb begin
      hit = '0;
      for (int k = 0; k < DEPTH; k++) begin
         hit[k] = used & writes_reg(sb[k]) & (sb[k].rd == rs_ext);
      end
   end

   // Search from the youngest stage outward so the most recent producer wins.
   always_comb begin
      found    = 1'b0;
      sel      = SEL_W'(FWD_RF);
      load_hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (hit[k] && !found) begin
            found = 1'b1;
            if (k == 0)
               sel = SEL_W'(FWD_EX_MEM);
            else if (k == 1)
               sel = SEL_W'(FWD_MEM_WB);
            else
               sel = SEL_W'(k + 1);
         end
         if ((k < LOAD_LAT) && hit[k] && sb[k].memread)
            load_hit = 1'b1;
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard controller: in-flight scoreboard, registered forward selects,
// load-use stall, taken-branch flush sequencing and saturating statistics.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no flush in progress; ID may issue
//   FLUSHING | flush asserted; fc counts remaining bubbles down to zero
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int  NUM_SRC   = 2,
   parameter int  REG_AW    = 5,
   parameter int  DEPTH     = 3,
   parameter int  LOAD_LAT  = 1,
   parameter int  FLUSH_CYC = 2,
   parameter int  CNT_W     = 16,
   localparam int SEL_W     = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
   input  logic [NUM_SRC-1:0]         id_rs_used,
   input  logic [REG_AW-1:0]          id_rd,
   input  logic                       id_regwrite,
   input  logic                       id_memread,
   input  logic                       branch_taken,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       stall,
   output logic                       flush,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           flush_cnt
);

   localparam int             FC_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYC - 1);

   sb_entry_t [DEPTH-1:0]      sb;
   sb_entry_t                  id_entry;
   logic [NUM_SRC*SEL_W-1:0]   sel_next;
   logic [NUM_SRC-1:0]         load_hit;
   logic                       issue;
   flush_state_t               state, state_nxt;
   logic [FC_W-1:0]            fc, fc_nxt;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_match #(
         .DEPTH    (DEPTH),
         .REG_AW   (REG_AW),
         .LOAD_LAT (LOAD_LAT),
         .SEL_W    (SEL_W)
      ) u_match (
         .sb       (sb),
         .rs       (id_rs[i*REG_AW +: REG_AW]),
         .used     (id_rs_used[i]),
         .sel      (sel_next[i*SEL_W +: SEL_W]),
         .load_hit (load_hit[i])
      );
   end

   // Flush outranks stall, so a squashed instruction never holds the PC.
   assign stall = id_valid & ~flush & (|load_hit);
   assign issue = id_valid & ~stall & ~flush;

   always_comb begin
      id_entry          = '0;
      id_entry.valid    = 1'b1;
      id_entry.rd       = RD_W_MAX'(id_rd);
      id_entry.regwrite = id_regwrite;
      id_entry.memread  = id_memread;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sb      <= '0;
         fwd_sel <= '0;
      end else begin
         sb[0]   <= issue ? id_entry : '0;
         for (int k = 1; k < DEPTH; k++) begin
            sb[k] <= sb[k-1];
         end
         fwd_sel <= issue ? sel_next : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         fc    <= '0;
      end else begin
         state <= state_nxt;
         fc    <= fc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fc_nxt    = fc;
      flush     = 1'b0;
      case (state)
         IDLE: begin
            if (branch_taken) begin
               state_nxt = FLUSHING;
               fc_nxt    = FC_RELOAD;
            end
         end
         FLUSHING: begin
            flush = 1'b1;
            if (branch_taken)
               fc_nxt = FC_RELOAD;
            else if (fc == '0)
               state_nxt = IDLE;
            else
               fc_nxt = fc - FC_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
